data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mips_mem_pkg.sv | 24 ++
 rtl/data_mem_array.sv | 48 ++++
 rtl/data_mem_responder.sv | 135 +++++++++++++
 tb/tb_data_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the data memory responder.
//   state_e   : responder FSM encoding (IDLE / WAIT / RESP)
//   mem_req_t : latched request payload (write, addr, wdata, be)
package mips_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = WORD_W / 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_req_t;

endpackage : mips_mem_pkg

// File: rtl/data_mem_array.sv
// Word-organised storage with per-byte-lane synchronous write and a
// registered read port. The storage itself is never reset; only the read
// register is.
//   clock, reset : clock and async active-low reset (read register only)
//   wr_en, be    : write enabled lanes of word idx with wdata
//   rd_en        : capture word idx into rdata
//   rd_clr       : clear rdata (ignored when rd_en is set)
//   rdata        : registered read data
module data_mem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-lane write; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register: holds its value until the next read or clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end else if (rd_clr) begin
      rdata <= '0;
    end
  end

endmodule : data_mem_array

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with a fixed response latency.
// A request accepted in IDLE waits WAIT_CYCLES cycles, then the store commits
// or the load is sampled on the edge entering RESP. The response is held until
// resp_ready.
//   clock, reset                  : clock and async active-low reset
//   req_valid/req_ready           : request handshake
//   req_write/addr/wdata/be       : request payload
//   resp_valid/resp_ready         : response handshake
//   resp_rdata, resp_error        : response payload (zero when not valid)
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_MEM_SIZE = 4096,
  parameter int unsigned WAIT_CYCLES   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_error
);

  localparam int unsigned DEPTH = DATA_MEM_SIZE / 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DATA_MEM_SIZE - 4);

  state_e            state, state_next;
  mem_req_t          req_in, req_q, req_act;
  logic              hs;
  logic              act_err;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              req_ready_d, resp_valid_d, resp_error_d;
  logic              wr_en, rd_en, rd_clr;
  logic [IDX_W-1:0]  arr_idx;

  // Incoming payload, and the request acting this cycle: with no wait
  // states the edge entering RESP is the handshake edge itself.
  always_comb begin
    req_in.write = req_write;
    req_in.addr  = req_addr;
    req_in.wdata = req_wdata;
    req_in.be    = req_be;
    hs           = (state == ST_IDLE) && req_valid;
    req_act      = hs ? req_in : req_q;
    act_err      = (req_act.addr[1:0] != 2'b00) || (req_act.addr > ADDR_MAX);
    arr_idx      = req_act.addr[IDX_W+1:2];
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == '0) state_next = ST_RESP;
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / datapath control: next values of registered outputs plus the
  // storage strobes, which fire only on the edge entering RESP.
  always_comb begin
    cnt_d        = cnt;
    req_ready_d  = (state_next == ST_IDLE);
    resp_valid_d = (state_next == ST_RESP);
    resp_error_d = resp_error;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_clr       = 1'b0;

    if (state == ST_IDLE && state_next == ST_WAIT) begin
      cnt_d = CNT_INIT;
    end else if (state == ST_WAIT && cnt != '0) begin
      cnt_d = cnt - CNT_W'(1);
    end

    if (state != ST_RESP && state_next == ST_RESP) begin
      resp_error_d = act_err;
      wr_en        = req_act.write && !act_err;
      rd_en        = !req_act.write && !act_err;
      rd_clr       = !rd_en;
    end else if (state == ST_RESP && state_next == ST_IDLE) begin
      resp_error_d = 1'b0;
      rd_clr       = 1'b1;
    end
  end

  // Registered outputs, counter and latched request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      req_q      <= '0;
    end else begin
      cnt        <= cnt_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_error <= resp_error_d;
      if (hs) req_q <= req_in;
    end
  end

  data_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .rd_clr (rd_clr),
    .idx    (arr_idx),
    .wdata  (req_act.wdata),
    .be     (req_act.be),
    .rdata  (resp_rdata)
  );

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT_CYCLES=2 (index 0)
// and one with WAIT_CYCLES=0 (index 1), checked against a byte-level
// memory model.
module tb_data_mem_responder;

  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

  logic        clock;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_error [2];

  logic [31:0] ref_mem [2][WORDS];
  logic [3:0]  known   [2][WORDS];

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_rd;
  logic        last_err;

  data_mem_responder #(.DATA_MEM_SIZE(MEM_BYTES), .WAIT_CYCLES(2)) dut_w2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
  );

  data_mem_responder #(.DATA_MEM_SIZE(MEM_BYTES), .WAIT_CYCLES(0)) dut_w0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int unsigned wait_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One complete transaction on instance u, hold = cycles resp_ready stays low
  // in RESP, junk = keep req_valid high with random payload while busy.
  task automatic do_txn(input int u, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int hold, input bit junk);
    logic        err;
    logic [31:0] exp_rd, mask, rd0;
    int          k;
    int unsigned wi;
    err    = (addr[1:0] != 2'b00) || (addr > 32'(MEM_BYTES - 4));
    wi     = err ? 0 : int'(addr >> 2);
    exp_rd = 32'h0;
    mask   = 32'hFFFF_FFFF;
    if (!err && !wr) begin
      exp_rd = ref_mem[u][wi];
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = known[u][wi][b] ? 8'hFF : 8'h00;
    end

    @(negedge clock);
    check("req_ready_idle", 32'(req_ready[u]), 32'd1);
    req_write[u] = wr; req_addr[u] = addr; req_wdata[u] = wd; req_be[u] = be;
    req_valid[u] = 1'b1;
    @(negedge clock);
    req_valid[u] = junk;
    req_write[u] = 1'($urandom); req_addr[u] = $urandom_range(0, 63) << 2;
    req_wdata[u] = $urandom; req_be[u] = 4'hF;
    k = 1;
    while (resp_valid[u] !== 1'b1 && k < 40) begin
      check("wait_rdata_zero", resp_rdata[u], 32'h0);
      check("wait_error_zero", 32'(resp_error[u]), 32'h0);
      check("wait_req_ready", 32'(req_ready[u]), 32'h0);
      @(negedge clock);
      k++;
    end
    check("latency", 32'(k), 32'(wait_of(u) + 1));
    check("resp_valid", 32'(resp_valid[u]), 32'd1);
    check("resp_error", 32'(resp_error[u]), 32'(err));
    check("resp_rdata", resp_rdata[u] & mask, exp_rd & mask);
    last_rd  = resp_rdata[u];
    last_err = resp_error[u];
    rd0 = resp_rdata[u];
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_valid", 32'(resp_valid[u]), 32'd1);
      check("hold_rdata", resp_rdata[u], rd0);
      check("hold_error", 32'(resp_error[u]), 32'(err));
      check("hold_req_ready", 32'(req_ready[u]), 32'd0);
    end
    req_valid[u]  = 1'b0;
    resp_ready[u] = 1'b1;
    @(negedge clock);
    resp_ready[u] = 1'b0;
    check("done_valid", 32'(resp_valid[u]), 32'd0);
    check("done_req_ready", 32'(req_ready[u]), 32'd1);
    check("done_rdata", resp_rdata[u], 32'h0);
    check("done_error", 32'(resp_error[u]), 32'd0);

    if (wr && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          ref_mem[u][wi][8*b +: 8] = wd[8*b +: 8];
          known[u][wi][b] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 0; req_write[u] = 0; req_addr[u] = 0;
      req_wdata[u] = 0; req_be[u] = 0; resp_ready[u] = 0;
      for (int w = 0; w < int'(WORDS); w++) begin
        ref_mem[u][w] = 32'h0;
        known[u][w]   = 4'h0;
      end
    end

    // Reset state
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      check("rst_resp_valid", 32'(resp_valid[u]), 32'd0);
      check("rst_rdata", resp_rdata[u], 32'h0);
      check("rst_error", 32'(resp_error[u]), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    check("rst_req_ready", 32'(req_ready[0]), 32'd1);

    // Full store then load
    do_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    check("st_full_err", 32'(last_err), 32'd0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, 1'b0);
    check("ld_full", last_rd, 32'hDEAD_BEEF);

    // Single-lane store merges with existing word
    do_txn(0, 1'b1, 32'h10, 32'h0000_00AA, 4'h1, 0, 1'b0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    check("ld_lane0", last_rd, 32'hDEAD_BEAA);

    // Misaligned and out-of-range loads
    do_txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0);
    check("misalign_err", 32'(last_err), 32'd1);
    check("misalign_rd", last_rd, 32'h0);
    do_txn(0, 1'b0, 32'd4096, 32'h0, 4'h0, 0, 1'b0);
    check("oor_err", 32'(last_err), 32'd1);
    // Erroring store must not write
    do_txn(0, 1'b1, 32'h11, 32'h1234_5678, 4'hF, 0, 1'b0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    check("after_err_ld", last_rd, 32'hDEAD_BEAA);

    // Zero byte enable store is a legal no-op
    do_txn(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 1'b0);
    check("be0_err", 32'(last_err), 32'd0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    check("be0_ld", last_rd, 32'hDEAD_BEAA);

    // Back-pressure with busy-time requests ignored
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);
    check("bp_ld", last_rd, 32'hDEAD_BEAA);

    // Reset during WAIT drops the pending store
    do_txn(0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, 1'b0);
    @(negedge clock);
    req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFE_F00D;
    req_be[0] = 4'hF; req_valid[0] = 1'b1;
    @(negedge clock);
    req_valid[0] = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(resp_valid[0]), 32'd0);
    check("mid_rst_rdata", resp_rdata[0], 32'h0);
    check("mid_rst_error", 32'(resp_error[0]), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 32'(req_ready[0]), 32'd1);
    check("post_rst_valid", 32'(resp_valid[0]), 32'd0);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
    check("post_rst_ld", last_rd, 32'h1234_5678);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    check("kept_ld", last_rd, 32'hDEAD_BEAA);

    // Zero-wait instance
    do_txn(1, 1'b1, 32'h40, 32'hA5A5_0F0F, 4'hF, 0, 1'b0);
    do_txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 2, 1'b1);
    check("w0_ld", last_rd, 32'hA5A5_0F0F);

    // Randomized traffic on both instances
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 60; n++) begin
        r = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 31)) << 2;
        if (r == 7)      a = a | 32'($urandom_range(1, 3));
        else if (r == 8) a = 32'd4096 + (32'($urandom_range(0, 3)) << 2);
        else if (r == 9) a = 32'hFFFF_FFFC;
        do_txn(u, 1'($urandom), a, $urandom, 4'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_data_mem_responder
